// File: rtl/x86_insn_encoder.sv
// Serialises one decoded x86-64 instruction (REX, escapes, opcode, ModRM, SIB,
// disp, imm) into a byte-wide valid/ready stream, one byte per cycle.
module x86_insn_encoder #(
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned LEN_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_map,
  input  logic [7:0]       in_opcode,
  input  logic             in_has_rex,
  input  logic [3:0]       in_rex_wrxb,
  input  logic             in_has_modrm,
  input  logic [7:0]       in_modrm,
  input  logic             in_has_sib,
  input  logic [7:0]       in_sib,
  input  logic [1:0]       in_disp_sz,
  input  logic [31:0]      in_disp,
  input  logic [2:0]       in_imm_sz,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len,
  output logic             err
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_REX, S_ESC0, S_ESC1, S_OPC, S_MODRM, S_SIB, S_DISP, S_IMM
  } state_e;

  typedef struct packed {
    logic [1:0]  map;
    logic [7:0]  opcode;
    logic        has_rex;
    logic [3:0]  wrxb;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [1:0]  disp_sz;
    logic [31:0] disp;
    logic [2:0]  imm_sz;
    logic [63:0] imm;
  } fields_t;

  state_e           state_q, state_d;
  fields_t          f_q, f_d, in_fields;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d, in_len_c;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             reject_c;
  logic [3:0]       map_b, disp_b, imm_b;

  // Whether an element of the instruction is present for the given fields.
  function automatic logic enabled(input state_e s, input fields_t f);
    logic e;
    e = 1'b0;
    case (s)
      S_REX:   e = f.has_rex;
      S_ESC0:  e = (f.map != 2'd0);
      S_ESC1:  e = f.map[1];
      S_OPC:   e = 1'b1;
      S_MODRM: e = f.has_modrm;
      S_SIB:   e = f.has_sib;
      S_DISP:  e = (f.disp_sz != 2'd0);
      S_IMM:   e = (f.imm_sz != 3'd0);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  function automatic state_e succ(input state_e s);
    state_e n;
    case (s)
      S_IDLE:  n = S_REX;
      S_REX:   n = S_ESC0;
      S_ESC0:  n = S_ESC1;
      S_ESC1:  n = S_OPC;
      S_OPC:   n = S_MODRM;
      S_MODRM: n = S_SIB;
      S_SIB:   n = S_DISP;
      S_DISP:  n = S_IMM;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // Next present element after s; S_IDLE when the instruction is complete.
  function automatic state_e next_el(input state_e s, input fields_t f);
    state_e c;
    c = succ(s);
    for (int i = 0; i < 8; i++) begin
      if (c != S_IDLE && !enabled(c, f)) c = succ(c);
    end
    return c;
  endfunction

  function automatic logic [3:0] nbytes(input state_e s, input fields_t f);
    logic [3:0] n;
    n = 4'd1;
    if (s == S_DISP) begin
      n = (f.disp_sz == 2'd1) ? 4'd1 : 4'd4;
    end else if (s == S_IMM) begin
      case (f.imm_sz)
        3'd1:    n = 4'd1;
        3'd2:    n = 4'd2;
        3'd3:    n = 4'd4;
        default: n = 4'd8;
      endcase
    end
    return n;
  endfunction

  function automatic logic [7:0] byte_of(input state_e s, input logic [IDX_W-1:0] idx,
                                         input fields_t f);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      S_REX:   b = {4'h4, f.wrxb};
      S_ESC0:  b = 8'h0F;
      S_ESC1:  b = (f.map == 2'd3) ? 8'h3A : 8'h38;
      S_OPC:   b = f.opcode;
      S_MODRM: b = f.modrm;
      S_SIB:   b = f.sib;
      S_DISP:  b = 8'(f.disp >> {idx[1:0], 3'b000});
      S_IMM:   b = 8'(f.imm >> {idx, 3'b000});
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic is_last(input state_e s, input logic [IDX_W-1:0] idx,
                                   input fields_t f);
    return (next_el(s, f) == S_IDLE) && (idx == IDX_W'(nbytes(s, f) - 4'd1));
  endfunction

  assign in_fields = '{
    map:       in_map,
    opcode:    in_opcode,
    has_rex:   in_has_rex,
    wrxb:      in_rex_wrxb,
    has_modrm: in_has_modrm,
    modrm:     in_modrm,
    has_sib:   in_has_sib,
    sib:       in_sib,
    disp_sz:   in_disp_sz,
    disp:      in_disp,
    imm_sz:    in_imm_sz,
    imm:       in_imm
  };

  // Request length and legality, evaluated on the raw inputs.
  always_comb begin
    map_b  = (in_map == 2'd0) ? 4'd0 : (in_map == 2'd1) ? 4'd1 : 4'd2;
    disp_b = (in_disp_sz == 2'd1) ? 4'd1 : (in_disp_sz == 2'd2) ? 4'd4 : 4'd0;
    case (in_imm_sz)
      3'd1:    imm_b = 4'd1;
      3'd2:    imm_b = 4'd2;
      3'd3:    imm_b = 4'd4;
      3'd4:    imm_b = 4'd8;
      default: imm_b = 4'd0;
    endcase
    in_len_c = LEN_W'(in_has_rex) + LEN_W'(map_b) + LEN_W'(1) + LEN_W'(in_has_modrm)
             + LEN_W'(in_has_sib) + LEN_W'(disp_b) + LEN_W'(imm_b);
    reject_c = (in_len_c > LEN_W'(MAX_LEN)) || (in_disp_sz == 2'd3) ||
               (in_imm_sz > 3'd4) || (in_has_sib && !in_has_modrm);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    idx_d       = idx_q;
    len_d       = len_q;
    err_d       = 1'b0;
    out_valid_d = 1'b0;
    out_byte_d  = 8'h00;
    out_last_d  = 1'b0;

    if (state_q == S_IDLE) begin
      if (in_valid && in_ready_q) begin
        if (reject_c) begin
          err_d = 1'b1;
        end else begin
          f_d     = in_fields;
          len_d   = in_len_c;
          idx_d   = '0;
          state_d = next_el(S_IDLE, in_fields);
        end
      end
    end else if (out_valid_q && out_ready) begin
      if (idx_q != IDX_W'(nbytes(state_q, f_q) - 4'd1)) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        idx_d   = '0;
        state_d = next_el(state_q, f_q);
      end
    end

    if (state_d != S_IDLE) begin
      out_valid_d = 1'b1;
      out_byte_d  = byte_of(state_d, idx_d, f_d);
      out_last_d  = is_last(state_d, idx_d, f_d);
    end
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      f_q         <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign out_len   = len_q;
  assign err       = err_q;

endmodule

// File: tb/tb_x86_insn_encoder.sv
// Directed bench for x86_insn_encoder: hand-computed byte streams, stalls,
// rejections and a mid-stream reset.
module tb_x86_insn_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_map;
  logic [7:0]  in_opcode;
  logic        in_has_rex;
  logic [3:0]  in_rex_wrxb;
  logic        in_has_modrm;
  logic [7:0]  in_modrm;
  logic        in_has_sib;
  logic [7:0]  in_sib;
  logic [1:0]  in_disp_sz;
  logic [31:0] in_disp;
  logic [2:0]  in_imm_sz;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [4:0]  out_len;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  x86_insn_encoder #(.MAX_LEN(15), .LEN_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_map(in_map), .in_opcode(in_opcode),
    .in_has_rex(in_has_rex), .in_rex_wrxb(in_rex_wrxb),
    .in_has_modrm(in_has_modrm), .in_modrm(in_modrm),
    .in_has_sib(in_has_sib), .in_sib(in_sib),
    .in_disp_sz(in_disp_sz), .in_disp(in_disp),
    .in_imm_sz(in_imm_sz), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last),
    .out_len(out_len), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the current negedge; returns at the negedge after accept.
  task automatic req(input logic rex, input logic [3:0] wrxb, input logic [1:0] map,
                     input logic [7:0] op, input logic hm, input logic [7:0] modrm,
                     input logic hs, input logic [7:0] sib, input logic [1:0] dsz,
                     input logic [31:0] disp, input logic [2:0] isz, input logic [63:0] imm);
    in_has_rex = rex;  in_rex_wrxb = wrxb; in_map = map;      in_opcode = op;
    in_has_modrm = hm; in_modrm = modrm;   in_has_sib = hs;   in_sib = sib;
    in_disp_sz = dsz;  in_disp = disp;     in_imm_sz = isz;   in_imm = imm;
    in_valid = 1'b1;
    check("in_ready_before_req", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consume n bytes (first byte in bytes' MSBs), stalling at byte stall_at for 3 cycles.
  task automatic collect(input string tag, input logic [127:0] bytes, input int n,
                         input int len, input int stall_at);
    logic [7:0] exp_b;
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) begin
        check($sformatf("%s timeout b%0d", tag, i), 64'(out_valid), 64'd1);
        return;
      end
      exp_b = bytes[8*(n-1-i) +: 8];
      check($sformatf("%s byte%0d", tag, i), 64'(out_byte), 64'(exp_b));
      check($sformatf("%s last%0d", tag, i), 64'(out_last), 64'(i == n-1));
      if (i == 0) begin
        check($sformatf("%s len", tag), 64'(out_len), 64'(len));
        check($sformatf("%s in_ready_busy", tag), 64'(in_ready), 64'd0);
      end
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("%s stall%0d byte", tag, k), 64'(out_byte), 64'(exp_b));
          check($sformatf("%s stall%0d valid", tag, k), 64'(out_valid), 64'd1);
          check($sformatf("%s stall%0d len", tag, k), 64'(out_len), 64'(len));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check($sformatf("%s bubble_valid", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s bubble_ready", tag), 64'(in_ready), 64'd1);
  endtask

  task automatic expect_reject(input string tag);
    check($sformatf("%s err", tag), 64'(err), 64'd1);
    check($sformatf("%s valid0", tag), 64'(out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("%s err_pulse", tag), 64'(err), 64'd0);
    check($sformatf("%s valid1", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s ready", tag), 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_has_rex = 0; in_rex_wrxb = 0; in_map = 0; in_opcode = 0;
    in_has_modrm = 0; in_modrm = 0; in_has_sib = 0; in_sib = 0;
    in_disp_sz = 0; in_disp = 0; in_imm_sz = 0; in_imm = 0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_byte", 64'(out_byte), 64'd0);
    check("rst out_last", 64'(out_last), 64'd0);
    check("rst out_len", 64'(out_len), 64'd0);
    check("rst err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    req(1, 4'h8, 0, 8'h01, 1, 8'hD8, 0, 0, 0, 0, 0, 0);
    collect("add", 128'h4801D8, 3, 3, -1);

    req(0, 0, 1, 8'h84, 0, 0, 0, 0, 0, 0, 3, 64'h10);
    collect("jz", 128'h0F8410000000, 6, 6, -1);

    req(1, 4'h9, 0, 8'hB8, 0, 0, 0, 0, 0, 0, 4, 64'h1122334455667788);
    collect("movabs", 128'h49B88877665544332211, 10, 10, -1);

    req(0, 0, 0, 8'h89, 1, 8'h84, 1, 8'h24, 2, 32'h12345678, 0, 0);
    collect("mov_sib", 128'h89842478563412, 7, 7, 2);

    req(0, 0, 2, 8'h00, 1, 8'hC1, 0, 0, 0, 0, 2, 64'hBEEF);
    collect("map2", 128'h0F3800C1EFBE, 6, 6, -1);

    req(1, 4'hF, 3, 8'h20, 1, 8'h44, 1, 8'h24, 1, 32'h7F, 4, 64'h0102030405060708);
    collect("len15", 128'h4F0F3A2044247F0807060504030201, 15, 15, -1);

    req(1, 4'hF, 3, 8'h20, 1, 8'h44, 1, 8'h24, 2, 0, 4, 0);
    expect_reject("rej_len18");
    req(0, 0, 3, 8'h20, 1, 8'h44, 0, 0, 2, 0, 4, 0);
    expect_reject("rej_len16");
    req(1, 4'h8, 0, 8'h01, 1, 8'hD8, 0, 0, 3, 0, 0, 0);
    expect_reject("rej_disp3");
    req(1, 4'h8, 0, 8'h01, 1, 8'hD8, 0, 0, 0, 0, 5, 0);
    expect_reject("rej_imm5");
    req(0, 0, 0, 8'h01, 0, 0, 1, 8'h24, 0, 0, 0, 0);
    expect_reject("rej_sib_nomodrm");

    // Abort movabs after its second byte has been taken.
    req(1, 4'h9, 0, 8'hB8, 0, 0, 0, 0, 0, 0, 4, 64'h1122334455667788);
    check("abort b0", 64'(out_byte), 64'h49);
    @(negedge clk);
    check("abort b1", 64'(out_byte), 64'hB8);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort valid", 64'(out_valid), 64'd0);
    check("abort last", 64'(out_last), 64'd0);
    check("abort len", 64'(out_len), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst ready", 64'(in_ready), 64'd1);
    check("post_rst valid", 64'(out_valid), 64'd0);
    req(1, 4'h8, 0, 8'h01, 1, 8'hD8, 0, 0, 0, 0, 0, 0);
    collect("add_after_rst", 128'h4801D8, 3, 3, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x86_insn_encoder.md
Name: x86_insn_encoder

Overview:
- Encodes one x86-64 instruction from decoded fields into its byte stream. Output is one byte per cycle in architectural order: REX, escape bytes, opcode, ModRM, SIB, displacement, immediate.
- This is the inverse of the opcode-map decode path. The bench uses it to generate decoder stimulus, and the design uses it to re-emit instructions into the fetch byte queue.
- Input side is a single-request valid/ready port. Output side is a byte-wide valid/ready stream with a last flag.

Parameters:
- MAX_LEN, 15, architectural instruction length limit in bytes. Requests longer than this are rejected.
- LEN_W, 5, width of the length counter and out_len. Must hold 18, the worst-case unchecked sum.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_map  in  2  opcode map: 0=one-byte, 1=0F, 2=0F 38, 3=0F 3A
- in_opcode  in  8  final opcode byte
- in_has_rex  in  1  emit REX prefix
- in_rex_wrxb  in  4  REX W,R,X,B bits; the emitted byte is 0x40 | wrxb
- in_has_modrm  in  1  emit ModRM
- in_modrm  in  8  ModRM byte
- in_has_sib  in  1  emit SIB; legal only with in_has_modrm
- in_sib  in  8  SIB byte
- in_disp_sz  in  2  displacement size: 0=none, 1=1B, 2=4B, 3=illegal
- in_disp  in  32  displacement, emitted little-endian
- in_imm_sz  in  3  immediate size: 0=none, 1=1B, 2=2B, 3=4B, 4=8B, 5..7=illegal
- in_imm  in  64  immediate, emitted little-endian
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts the byte
- out_byte  out  8  encoded byte
- out_last  out  1  final byte of the instruction
- out_len  out  LEN_W  total length of the current instruction; stable while busy
- err  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - out_valid=0, out_byte=0, out_last=0, out_len=0, err=0.
  - All captured fields are cleared.
  - in_ready=1 from the first clk edge after reset_n rises.
- States: IDLE, REX, ESC0, ESC1, OPC, MODRM, SIB, DISP, IMM.
- in_ready is 1 only in IDLE.
- Accept occurs when in_valid & in_ready on a rising edge. On accept:
  - All inputs are registered.
  - Length is computed as rex + map bytes (0/1/2/2) + 1 + modrm + sib + disp bytes + imm bytes.
- Rejection. A request is rejected if any of these holds:
  - length > MAX_LEN
  - in_disp_sz==3
  - in_imm_sz > 4
  - in_has_sib without in_has_modrm
  On rejection, err pulses high the next cycle, no byte is emitted, and the state stays IDLE.
- Latency: the first byte is valid in the cycle after accept, with out_len valid in that same cycle.
- The first state is the first enabled element in the order REX→ESC0→ESC1→OPC→MODRM→SIB→DISP→IMM.
- Bytes per state:
  - ESC0 emits 0x0F.
  - ESC1 emits 0x38 (map 2) or 0x3A (map 3).
  - OPC always occurs.
- Advance: on out_valid & out_ready the FSM moves to the next enabled element in the order above.
  - DISP and IMM each use a byte-index counter and emit byte[idx] = field[8*idx +: 8], starting at idx=0.
  - The counter clears on leaving the state.
- Backpressure: while out_valid & !out_ready, out_byte, out_last and out_len hold stable. No state or counter change occurs.
- out_last is 1 exactly on the final byte. After its handshake, the state returns to IDLE and out_valid=0 the next cycle.
- One bubble cycle always separates consecutive instructions.
- The count of emitted bytes always equals out_len. The assertion covers this.
- in_valid while busy is ignored: in_ready=0 and the input is not captured.
- Reset mid-stream aborts immediately. No out_last is produced for the aborted instruction.

Test Plan:
- add rax,rbx: rex=1, wrxb=1000, map 0, op 01, modrm D8 → bytes 48 01 D8; out_last on D8; out_len=3.
- jz rel32: map 1, op 84, imm_sz 3, imm 0x10 → 0F 84 10 00 00 00; out_len=6.
- movabs r8,imm64: rex wrxb=1001, op B8, imm_sz 4, imm 0x1122334455667788 → 49 B8 88 77 66 55 44 33 22 11; out_len=10.
- mov [rsp+0x12345678],eax with backpressure:
  - Stimulus: map 0, op 89, modrm 84, sib 24, disp_sz 2, disp 0x12345678; out_ready low 3 cycles at the SIB byte.
  - Required: 89 84 24 held through the stall, then 78 56 34 12; out_len=7.
- Rejection:
  - rex + map 3 + modrm + sib + disp4 + imm8 (length 18) → err=1 for exactly 1 cycle; out_valid stays 0; in_ready returns to 1.
  - Repeat with disp_sz=3 → same response.
- Reset mid-stream: assert reset_n=0 after the 2nd byte of the movabs case → out_valid=0 immediately. After release, a new add request emits 48 01 D8 cleanly.
